dm_mem_bus_ctrl: RTL and testbench

- Slave-side controller placed between the hart-facing system bus port and the debug memory datapath.
- Accepts single-beat requests and decodes the debug address map.
- Issues one-cycle write/read strobes (wr_*_en / rd_*_en, req to ROM) and sequences the response.
- Returns rvalid exactly one cycle after grant, plus an error flag for illegal accesses. Tracks per-hart halt-notify ordering for the control unit.

---
 rtl/dm_mem_bus_ctrl_pkg.sv | 49 ++++
 rtl/dm_mem_bus_ctrl_if.sv | 29 ++
 rtl/dm_addr_decode.sv | 75 +++++++
 rtl/dm_mem_bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_dm_mem_bus_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_mem_bus_ctrl_pkg.sv
// Shared definitions for the debug-memory bus controller.
//   - addr_t        : byte address type used for all decode arithmetic
//   - fixed debug address map constants (halt-notify and where-to registers,
//     flags window)
//   - region_e      : decoded target of a bus access
//   - state_e       : response sequencer states
//   - in_range()    : inclusive address-window test
package dm_mem_bus_ctrl_pkg;

  typedef logic [31:0] addr_t;

  // Hart-to-debugger notification registers (write only).
  localparam addr_t HaltedAddr    = 32'h100;
  localparam addr_t GoingAddr     = 32'h108;
  localparam addr_t ResumingAddr  = 32'h110;
  localparam addr_t ExceptionAddr = 32'h118;

  // Read-only locations.
  localparam addr_t WhereToAddr   = 32'h300;
  localparam addr_t FlagsBase     = 32'h400;
  localparam addr_t FlagsEnd      = 32'h7FF;

  // The abstract-command block sits directly below the program buffer.
  localparam int unsigned AbsCmdBytes = 40;

  typedef enum logic [3:0] {
    REG_NONE,
    REG_HALTED,
    REG_GOING,
    REG_RESUMING,
    REG_EXCEPTION,
    REG_DATA,
    REG_WHERE,
    REG_PROG,
    REG_ABS_CMD,
    REG_FLAGS,
    REG_ROM
  } region_e;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  function automatic logic in_range(input addr_t a, input addr_t lo, input addr_t hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/dm_mem_bus_ctrl_if.sv
// Single-beat system-bus port between a hart-side master and the debug
// memory controller.
//   req/we/addr/wdata/be : request phase, driven by the master
//   gnt                  : grant, same cycle as the request is accepted
//   rvalid/err           : response phase, one cycle after grant
interface dm_mem_bus_ctrl_if #(
  parameter int unsigned BusWidth = 32
) ();

  logic                req;
  logic                we;
  logic [BusWidth-1:0] addr;
  logic [31:0]         wdata;
  logic [3:0]          be;
  logic                gnt;
  logic                rvalid;
  logic                err;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, err
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, err
  );

endinterface

// File: rtl/dm_addr_decode.sv
// Combinational decoder for the debug address map.
//   addr_i    : low DbgAddressBits of the bus address (upper bits aliased away)
//   we_i      : access direction, 1 = write
//   be_i      : byte enables; a write with no lanes enabled is a legal no-op
//   region_o  : decoded target region (REG_NONE when nothing is addressed)
//   illegal_o : access hits no legal location for its direction
module dm_addr_decode
  import dm_mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned DbgAddressBits = 12,
  parameter addr_t       DataAddr       = 32'h380,
  parameter int unsigned DataCount      = 2,
  parameter int unsigned ProgBufSize    = 8,
  parameter addr_t       HaltAddress    = 32'h800
) (
  input  logic [DbgAddressBits-1:0] addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  output region_e                   region_o,
  output logic                      illegal_o
);

  // Windows that depend on the configured data/progbuf sizes.
  localparam addr_t DataEnd    = DataAddr + addr_t'(4 * DataCount) - 32'd1;
  localparam addr_t ProgBase   = DataAddr - addr_t'(4 * ProgBufSize);
  localparam addr_t ProgEnd    = DataAddr - 32'd1;
  localparam addr_t AbsCmdBase = ProgBase - addr_t'(AbsCmdBytes);
  localparam addr_t AbsCmdEnd  = ProgBase - 32'd1;

  addr_t a;
  assign a = addr_t'(addr_i);

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    region_o  = REG_NONE;
    illegal_o = 1'b0;
    if (we_i) begin
      if (be_i == 4'h0) begin
        region_o = REG_NONE;
      end else if (a == HaltedAddr) begin
        region_o = REG_HALTED;
      end else if (a == GoingAddr) begin
        region_o = REG_GOING;
      end else if (a == ResumingAddr) begin
        region_o = REG_RESUMING;
      end else if (a == ExceptionAddr) begin
        region_o = REG_EXCEPTION;
      end else if (in_range(a, DataAddr, DataEnd)) begin
        region_o = REG_DATA;
      end else begin
        illegal_o = 1'b1;
      end
    end else begin
      if (a == WhereToAddr) begin
        region_o = REG_WHERE;
      end else if (in_range(a, DataAddr, DataEnd)) begin
        region_o = REG_DATA;
      end else if (in_range(a, ProgBase, ProgEnd)) begin
        region_o = REG_PROG;
      end else if (in_range(a, AbsCmdBase, AbsCmdEnd)) begin
        region_o = REG_ABS_CMD;
      end else if (in_range(a, FlagsBase, FlagsEnd)) begin
        region_o = REG_FLAGS;
      end else if (a >= HaltAddress) begin
        // ROM: served by the datapath via mem_req_o, no dedicated strobe.
        region_o = REG_ROM;
      end else begin
        // The datapath still returns something; the bus discards it.
        illegal_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_mem_bus_ctrl.sv
// Slave-side controller between the hart system-bus port and the debug
// memory datapath.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   bus                    : slave side of the single-beat request/response port
//   wr_*_en_o              : one-cycle write strobes in the accept cycle
//   wr_data_addr_o         : byte address accompanying wr_data_en_o
//   rd_*_en_o              : one-cycle read strobes in the accept cycle
//   rd_addr_o              : read address, holds the last read when idle
//   mem_req_o              : datapath/ROM request, asserted for every read
//   halt_pending_o         : halted notified, going/resuming not yet seen
//   access_cnt_o           : saturating count of accepted transactions
module dm_mem_bus_ctrl
  import dm_mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned DbgAddressBits = 12,
  parameter int unsigned BusWidth       = 32,
  parameter addr_t       DataAddr       = 32'h380,
  parameter int unsigned DataCount      = 2,
  parameter int unsigned ProgBufSize    = 8,
  parameter addr_t       HaltAddress    = 32'h800
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dm_mem_bus_ctrl_if.slave    bus,
  output logic                wr_halted_en_o,
  output logic                wr_going_en_o,
  output logic                wr_resuming_en_o,
  output logic                wr_exception_en_o,
  output logic                wr_data_en_o,
  output logic [BusWidth-1:0] wr_data_addr_o,
  output logic                rd_where_en_o,
  output logic                rd_data_en_o,
  output logic                rd_prog_en_o,
  output logic                rd_abs_cmd_en_o,
  output logic                rd_flags_en_o,
  output logic [BusWidth-1:0] rd_addr_o,
  output logic                mem_req_o,
  output logic                halt_pending_o,
  output logic [15:0]         access_cnt_o
);

  state_e              state_q;
  logic                err_q;
  logic                halt_pending_q;
  logic [15:0]         access_cnt_q;
  logic [BusWidth-1:0] rd_addr_q;

  region_e region;
  logic    illegal;
  logic    accept;
  logic    rd_accept;

  // Write data is consumed by the datapath directly from the bus.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata;

  dm_addr_decode #(
    .DbgAddressBits (DbgAddressBits),
    .DataAddr       (DataAddr),
    .DataCount      (DataCount),
    .ProgBufSize    (ProgBufSize),
    .HaltAddress    (HaltAddress)
  ) u_addr_decode (
    .addr_i    (bus.addr[DbgAddressBits-1:0]),
    .we_i      (bus.we),
    .be_i      (bus.be),
    .region_o  (region),
    .illegal_o (illegal)
  );

  // Never stalls: every request is granted and accepted in its own cycle.
  assign bus.gnt   = bus.req;
  assign accept    = bus.req;
  assign rd_accept = accept & ~bus.we;

  always_comb begin
    wr_halted_en_o    = 1'b0;
    wr_going_en_o     = 1'b0;
    wr_resuming_en_o  = 1'b0;
    wr_exception_en_o = 1'b0;
    wr_data_en_o      = 1'b0;
    rd_where_en_o     = 1'b0;
    rd_data_en_o      = 1'b0;
    rd_prog_en_o      = 1'b0;
    rd_abs_cmd_en_o   = 1'b0;
    rd_flags_en_o     = 1'b0;
    if (accept) begin
      unique case (region)
        REG_HALTED:    wr_halted_en_o    = 1'b1;
        REG_GOING:     wr_going_en_o     = 1'b1;
        REG_RESUMING:  wr_resuming_en_o  = 1'b1;
        REG_EXCEPTION: wr_exception_en_o = 1'b1;
        REG_DATA: begin
          // Data words are the only region reachable in both directions.
          if (bus.we) wr_data_en_o = 1'b1;
          else        rd_data_en_o = 1'b1;
        end
        REG_WHERE:     rd_where_en_o     = 1'b1;
        REG_PROG:      rd_prog_en_o      = 1'b1;
        REG_ABS_CMD:   rd_abs_cmd_en_o   = 1'b1;
        REG_FLAGS:     rd_flags_en_o     = 1'b1;
        default: begin end
      endcase
    end
  end

  assign wr_data_addr_o = bus.addr;
  assign mem_req_o      = rd_accept;
  // Current address during a read, otherwise the last read address.
  assign rd_addr_o      = rd_accept ? bus.addr : rd_addr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      err_q          <= 1'b0;
      halt_pending_q <= 1'b0;
      access_cnt_q   <= '0;
      rd_addr_q      <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept)  state_q <= ST_RESP;
        ST_RESP: if (!accept) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      // Low whenever no response is owed, so err_o is clean outside rvalid_o.
      err_q <= accept & illegal;

      // Clear has priority over set.
      if (wr_going_en_o || wr_resuming_en_o) begin
        halt_pending_q <= 1'b0;
      end else if (wr_halted_en_o) begin
        halt_pending_q <= 1'b1;
      end

      if (accept && (access_cnt_q != 16'hFFFF)) begin
        access_cnt_q <= access_cnt_q + 16'd1;
      end

      if (rd_accept) begin
        rd_addr_q <= bus.addr;
      end
    end
  end

  assign bus.rvalid     = (state_q == ST_RESP);
  assign bus.err        = err_q;
  assign halt_pending_o = halt_pending_q;
  assign access_cnt_o   = access_cnt_q;

endmodule

// File: tb/tb_dm_mem_bus_ctrl.sv
// Self-checking bench for dm_mem_bus_ctrl. A driver issues requests and
// checks the accept-cycle strobes against a reference model of the address
// map; expected responses go into a scoreboard queue that an independent
// monitor drains whenever the controller shows rvalid.
module tb_dm_mem_bus_ctrl;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  dm_mem_bus_ctrl_if #(.BusWidth(32)) bus ();

  logic        wr_halted_en_o, wr_going_en_o, wr_resuming_en_o;
  logic        wr_exception_en_o, wr_data_en_o;
  logic [31:0] wr_data_addr_o;
  logic        rd_where_en_o, rd_data_en_o, rd_prog_en_o;
  logic        rd_abs_cmd_en_o, rd_flags_en_o;
  logic [31:0] rd_addr_o;
  logic        mem_req_o;
  logic        halt_pending_o;
  logic [15:0] access_cnt_o;

  dm_mem_bus_ctrl dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .bus               (bus),
    .wr_halted_en_o    (wr_halted_en_o),
    .wr_going_en_o     (wr_going_en_o),
    .wr_resuming_en_o  (wr_resuming_en_o),
    .wr_exception_en_o (wr_exception_en_o),
    .wr_data_en_o      (wr_data_en_o),
    .wr_data_addr_o    (wr_data_addr_o),
    .rd_where_en_o     (rd_where_en_o),
    .rd_data_en_o      (rd_data_en_o),
    .rd_prog_en_o      (rd_prog_en_o),
    .rd_abs_cmd_en_o   (rd_abs_cmd_en_o),
    .rd_flags_en_o     (rd_flags_en_o),
    .rd_addr_o         (rd_addr_o),
    .mem_req_o         (mem_req_o),
    .halt_pending_o    (halt_pending_o),
    .access_cnt_o      (access_cnt_o)
  );

  // One-hot strobe codes, in the bit order of act_strb below.
  localparam logic [9:0] S_NONE     = 10'b0;
  localparam logic [9:0] S_HALTED   = 10'b10_0000_0000;
  localparam logic [9:0] S_GOING    = 10'b01_0000_0000;
  localparam logic [9:0] S_RESUMING = 10'b00_1000_0000;
  localparam logic [9:0] S_EXCEPT   = 10'b00_0100_0000;
  localparam logic [9:0] S_WDATA    = 10'b00_0010_0000;
  localparam logic [9:0] S_WHERE    = 10'b00_0001_0000;
  localparam logic [9:0] S_RDATA    = 10'b00_0000_1000;
  localparam logic [9:0] S_PROG     = 10'b00_0000_0100;
  localparam logic [9:0] S_ABS      = 10'b00_0000_0010;
  localparam logic [9:0] S_FLAGS    = 10'b00_0000_0001;

  wire [9:0] act_strb = {wr_halted_en_o, wr_going_en_o, wr_resuming_en_o,
                         wr_exception_en_o, wr_data_en_o, rd_where_en_o,
                         rd_data_en_o, rd_prog_en_o, rd_abs_cmd_en_o,
                         rd_flags_en_o};

  typedef struct {
    int unsigned due;
    logic        err;
  } exp_rsp_t;

  exp_rsp_t    sb_q[$];
  int unsigned cyc      = 0;
  int unsigned n_cmp    = 0;
  int unsigned n_err    = 0;

  // Reference state.
  logic        m_halt    = 1'b0;
  int unsigned m_cnt     = 0;
  logic [31:0] m_last_rd = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Address map reference: debug address is the byte address modulo 4 KiB.
  //   data 0x380..0x387, progbuf 0x360..0x37F, abstract cmd 0x338..0x35F,
  //   flags 0x400..0x7FF, ROM 0x800 and up.
  function automatic void ref_model(input logic we, input logic [31:0] addr,
                                    input logic [3:0] be,
                                    output logic [9:0] strb, output logic err);
    int unsigned a;
    a    = addr % 4096;
    strb = S_NONE;
    err  = 1'b0;
    if (we) begin
      if (be == 4'h0)                   strb = S_NONE;
      else if (a == 'h100)              strb = S_HALTED;
      else if (a == 'h108)              strb = S_GOING;
      else if (a == 'h110)              strb = S_RESUMING;
      else if (a == 'h118)              strb = S_EXCEPT;
      else if (a >= 'h380 && a <= 'h387) strb = S_WDATA;
      else                              err  = 1'b1;
    end else begin
      if (a == 'h300)                   strb = S_WHERE;
      else if (a >= 'h380 && a <= 'h387) strb = S_RDATA;
      else if (a >= 'h360 && a <= 'h37F) strb = S_PROG;
      else if (a >= 'h338 && a <= 'h35F) strb = S_ABS;
      else if (a >= 'h400 && a <= 'h7FF) strb = S_FLAGS;
      else if (a >= 'h800)              strb = S_NONE;
      else                              err  = 1'b1;
    end
  endfunction

  task automatic check_state();
    check("halt_pending", 32'(halt_pending_o), 32'(m_halt));
    check("access_cnt", 32'(access_cnt_o), m_cnt);
  endtask

  // Called just after a falling edge; returns on the next falling edge.
  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
    logic [9:0] e_strb;
    logic       e_err;
    check_state();
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = addr;
    bus.be    = be;
    bus.wdata = wdata;
    #2;
    ref_model(we, addr, be, e_strb, e_err);
    check("gnt", 32'(bus.gnt), 32'd1);
    check("strobes", 32'(act_strb), 32'(e_strb));
    check("mem_req", 32'(mem_req_o), 32'(!we));
    if (!we) m_last_rd = addr;
    check("rd_addr", rd_addr_o, m_last_rd);
    if (e_strb == S_WDATA) check("wr_data_addr", wr_data_addr_o, addr);
    sb_q.push_back('{due: cyc + 1, err: e_err});
    if (e_strb == S_GOING || e_strb == S_RESUMING) m_halt = 1'b0;
    else if (e_strb == S_HALTED)                    m_halt = 1'b1;
    if (m_cnt < 'hFFFF) m_cnt++;
    @(negedge clk_i);
  endtask

  task automatic do_idle();
    check_state();
    bus.req = 1'b0;
    #2;
    check("idle_gnt", 32'(bus.gnt), 32'd0);
    check("idle_strobes", 32'(act_strb), 32'(S_NONE));
    check("idle_mem_req", 32'(mem_req_o), 32'd0);
    check("idle_rd_addr", rd_addr_o, m_last_rd);
    @(negedge clk_i);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 11))
      0:       a = 32'h100;
      1:       a = 32'h108;
      2:       a = 32'h110;
      3:       a = 32'h118;
      4:       a = 32'h380 + $urandom_range(0, 7);
      5:       a = 32'h360 + $urandom_range(0, 31);
      6:       a = 32'h338 + $urandom_range(0, 39);
      7:       a = 32'h400 + $urandom_range(0, 'h3FF);
      8:       a = 32'h800 + $urandom_range(0, 'h7FF);
      9:       a = 32'h300;
      default: a = $urandom & 32'hFFF;
    endcase
    // Upper bits must alias onto the same debug address.
    if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
    return a;
  endfunction

  task automatic rand_access();
    logic [3:0] be;
    be = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 4'hF;
    do_access($urandom_range(0, 1), rand_addr(), be, $urandom);
  endtask

  // Cycle counter and response monitor.
  always @(posedge clk_i) cyc <= cyc + 1;

  always begin
    logic     e_rv;
    exp_rsp_t e;
    @(posedge clk_i);
    #1;
    if (rst_ni) begin
      e_rv = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      check("rvalid", 32'(bus.rvalid), 32'(e_rv));
      if (e_rv) begin
        e = sb_q.pop_front();
        check("err", 32'(bus.err), 32'(e.err));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.be    = '0;
    #3;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_strobes", 32'(act_strb), 32'(S_NONE));
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check_state();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_idle();

    // Halt-notify ordering, back-to-back writes.
    do_access(1'b1, 32'h100, 4'hF, 32'h0);
    do_access(1'b1, 32'h108, 4'hF, 32'h0);
    do_access(1'b1, 32'h100, 4'hF, 32'h0);
    do_access(1'b1, 32'h110, 4'hF, 32'h0);
    do_idle();
    // Directed decode points.
    do_access(1'b0, 32'h384, 4'hF, 32'h0);
    do_access(1'b0, 32'h340, 4'hF, 32'h0);
    do_access(1'b0, 32'h360, 4'hF, 32'h0);
    do_access(1'b0, 32'h35F, 4'hF, 32'h0);
    do_access(1'b0, 32'h337, 4'hF, 32'h0);
    do_access(1'b0, 32'h388, 4'hF, 32'h0);
    do_access(1'b1, 32'h300, 4'hF, 32'h0);
    do_access(1'b0, 32'h804, 4'hF, 32'h0);
    do_idle();
    do_access(1'b1, 32'h100, 4'h0, 32'h0);
    do_access(1'b1, 32'h118, 4'h1, 32'h5);
    do_access(1'b1, 32'h387, 4'hF, 32'hDEAD_BEEF);
    do_access(1'b1, 32'h388, 4'hF, 32'h1);
    do_access(1'b0, 32'h300, 4'hF, 32'h0);
    do_access(1'b0, 32'h400, 4'hF, 32'h0);
    do_access(1'b0, 32'h7FF, 4'hF, 32'h0);
    do_access(1'b0, 32'h200, 4'hF, 32'h0);
    do_access(1'b1, 32'h804, 4'hF, 32'h0);
    do_access(1'b0, 32'hABCD_E384, 4'hF, 32'h0);
    do_idle();
    do_idle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) do_idle();
      else rand_access();
    end

    // Reset while a response is being presented.
    do_access(1'b1, 32'h100, 4'hF, 32'h0);
    do_access(1'b0, 32'h384, 4'hF, 32'h0);
    bus.req = 1'b0;
    rst_ni  = 1'b0;
    #1;
    check("rst_mid_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_mid_cnt", 32'(access_cnt_o), 32'd0);
    check("rst_mid_halt", 32'(halt_pending_o), 32'd0);
    sb_q.delete();
    m_halt    = 1'b0;
    m_cnt     = 0;
    m_last_rd = 32'h0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_idle();
    do_idle();

    // Saturation of the transaction counter.
    for (int i = 0; i < 70000; i++) rand_access();
    do_idle();
    do_idle();
    check("sat_cnt", 32'(access_cnt_o), 32'hFFFF);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
